// File: rtl/ahb_imem_responder.sv
// AHB3-Lite instruction-fetch responder: returns a supplied word after programmable wait
// states, rejects illegal fetches with a two-cycle ERROR, and emits a fetch log with counters.
module ahb_imem_responder #(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE  = 32'h0001_0000,
  parameter int unsigned MAX_WAIT   = 15,
  parameter logic [31:0] RESET_INSN = 32'h0000_0013
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic [31:0] insn_i,
  input  logic [3:0]  wait_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_addr_o,
  output logic [31:0] fetch_data_o,
  output logic [31:0] fetch_cnt_o,
  output logic [15:0] err_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [3:0]  MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [32:0] WIN_LO     = {1'b0, ADDR_BASE};
  localparam logic [32:0] WIN_HI     = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] hrdata_reg, hrdata_next;
  logic [31:0] fetch_addr_reg, fetch_addr_next;
  logic [31:0] fetch_cnt_reg, fetch_cnt_next;
  logic [15:0] err_cnt_reg, err_cnt_next;

  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic        out_of_window;
  logic [32:0] haddr_ext;
  logic [3:0]  wait_clamped;

  // Burst type and protection carry no meaning for an instruction memory.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT};

  assign accept        = HSEL & HREADY & HTRANS[1];
  assign haddr_ext     = {1'b0, HADDR};
  assign out_of_window = (haddr_ext < WIN_LO) || (haddr_ext >= WIN_HI);
  assign misaligned    = ((HSIZE == 3'd1) && HADDR[0]) ||
                         ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  assign illegal       = HWRITE || (HSIZE > 3'd2) || misaligned || out_of_window;
  assign wait_clamped  = (wait_i > MAX_WAIT_C) ? MAX_WAIT_C : wait_i;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    addr_next       = addr_reg;
    hrdata_next     = hrdata_reg;
    fetch_addr_next = fetch_addr_reg;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        state_next = ST_IDLE;
        if (accept) begin
          addr_next = HADDR;
          if (illegal) begin
            state_next = ST_ERR1;
          end else if (wait_i == 4'd0) begin
            hrdata_next     = insn_i;
            fetch_addr_next = HADDR;
            state_next      = ST_DONE;
          end else begin
            cnt_next   = wait_clamped;
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg > 4'd1) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          hrdata_next     = insn_i;
          fetch_addr_next = addr_reg;
          state_next      = ST_DONE;
        end
      end
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
  end

  // DONE and ERR1 are only ever entered once per completion/rejection, so counting entries is exact.
  always_comb begin
    fetch_cnt_next = fetch_cnt_reg;
    err_cnt_next   = err_cnt_reg;
    if ((state_next == ST_DONE) && (fetch_cnt_reg != 32'hFFFF_FFFF)) begin
      fetch_cnt_next = fetch_cnt_reg + 32'd1;
    end
    if ((state_next == ST_ERR1) && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_next = err_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 4'd0;
      addr_reg       <= 32'd0;
      hrdata_reg     <= RESET_INSN;
      fetch_addr_reg <= 32'd0;
      fetch_cnt_reg  <= 32'd0;
      err_cnt_reg    <= 16'd0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      addr_reg       <= addr_next;
      hrdata_reg     <= hrdata_next;
      fetch_addr_reg <= fetch_addr_next;
      fetch_cnt_reg  <= fetch_cnt_next;
      err_cnt_reg    <= err_cnt_next;
    end
  end

  assign HREADYOUT     = !((state_reg == ST_WAIT) || (state_reg == ST_ERR1));
  assign HRESP         = (state_reg == ST_ERR1) || (state_reg == ST_ERR2);
  assign HRDATA        = hrdata_reg;
  assign fetch_valid_o = (state_reg == ST_DONE);
  assign fetch_addr_o  = fetch_addr_reg;
  assign fetch_data_o  = hrdata_reg;
  assign fetch_cnt_o   = fetch_cnt_reg;
  assign err_cnt_o     = err_cnt_reg;

endmodule

// File: tb/tb_ahb_imem_responder.sv
// Directed vector bench for ahb_imem_responder: one table row per clock, plus a
// hand-written wait-state sequence measured against a cycle budget.
module tb_ahb_imem_responder;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] insn_i;
  logic [3:0]  wait_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_addr_o;
  logic [31:0] fetch_data_o;
  logic [31:0] fetch_cnt_o;
  logic [15:0] err_cnt_o;

  always #5 HCLK = ~HCLK;

  ahb_imem_responder #(
    .ADDR_BASE (32'h0000_0000),
    .ADDR_SIZE (32'h0001_0000),
    .MAX_WAIT  (4),
    .RESET_INSN(32'h0000_0013)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HSEL         (HSEL),
    .HADDR        (HADDR),
    .HWRITE       (HWRITE),
    .HSIZE        (HSIZE),
    .HBURST       (HBURST),
    .HPROT        (HPROT),
    .HTRANS       (HTRANS),
    .HREADY       (HREADY),
    .HRDATA       (HRDATA),
    .HREADYOUT    (HREADYOUT),
    .HRESP        (HRESP),
    .insn_i       (insn_i),
    .wait_i       (wait_i),
    .fetch_valid_o(fetch_valid_o),
    .fetch_addr_o (fetch_addr_o),
    .fetch_data_o (fetch_data_o),
    .fetch_cnt_o  (fetch_cnt_o),
    .err_cnt_o    (err_cnt_o)
  );

  typedef struct {
    logic        rst;
    logic        hsel;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hready;
    logic [31:0] insn;
    logic [3:0]  wt;
    logic        e_ro;
    logic        e_resp;
    logic [31:0] e_rdata;
    logic        e_v;
    logic [31:0] e_fa;
    logic [31:0] e_fc;
    logic [15:0] e_ec;
  } vec_t;

  localparam logic [1:0] ID = 2'd0, BZ = 2'd1, NS = 2'd2, SQ = 2'd3;

  vec_t vq[$];
  int   vectors_applied = 0;
  int   miscompares     = 0;

  task automatic add(input logic rst, input logic hsel, input logic [1:0] htrans,
                     input logic [31:0] haddr, input logic hwrite, input logic [2:0] hsize,
                     input logic hready, input logic [31:0] insn, input logic [3:0] wt,
                     input logic e_ro, input logic e_resp, input logic [31:0] e_rdata,
                     input logic e_v, input logic [31:0] e_fa, input logic [31:0] e_fc,
                     input logic [15:0] e_ec);
    vec_t v;
    v = '{rst, hsel, htrans, haddr, hwrite, hsize, hready, insn, wt,
          e_ro, e_resp, e_rdata, e_v, e_fa, e_fc, e_ec};
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL vec %0d %s: got %h want %h", idx, nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    HRESET = 1'b0; HSEL = 1'b0; HTRANS = ID; HADDR = 32'd0; HWRITE = 1'b0;
    HSIZE = 3'd2; HREADY = 1'b1; insn_i = 32'd0; wait_i = 4'd0;
  endtask

  initial begin
    int lows;
    int cycles;
    HBURST = 3'd0;
    HPROT  = 4'd0;
    drive_idle();
    HRESET = 1'b1;

    //  rst hsel htrans addr          wr size rdy insn           wt   ro rsp rdata          v  faddr          fcnt ecnt
    add(1, 0, ID, 32'h0000_0000, 0, 2, 1, 32'h0000_0000, 0,   1, 0, 32'h0000_0013, 0, 32'h0000_0000, 0, 0);
    add(1, 0, ID, 32'h0000_0000, 0, 2, 1, 32'h0000_0000, 0,   1, 0, 32'h0000_0013, 0, 32'h0000_0000, 0, 0);
    add(0, 1, NS, 32'h0000_0200, 0, 2, 1, 32'h0050_0093, 0,   1, 0, 32'h0050_0093, 1, 32'h0000_0200, 1, 0);
    add(0, 1, SQ, 32'h0000_0200, 0, 2, 1, 32'h0010_0113, 0,   1, 0, 32'h0010_0113, 1, 32'h0000_0200, 2, 0);
    add(0, 1, SQ, 32'h0000_0204, 0, 2, 1, 32'h0020_0193, 0,   1, 0, 32'h0020_0193, 1, 32'h0000_0204, 3, 0);
    add(0, 1, SQ, 32'h0000_0208, 0, 2, 1, 32'h0030_0213, 0,   1, 0, 32'h0030_0213, 1, 32'h0000_0208, 4, 0);
    add(0, 1, SQ, 32'h0000_020C, 0, 2, 1, 32'h0040_0293, 0,   1, 0, 32'h0040_0293, 1, 32'h0000_020C, 5, 0);
    add(0, 0, ID, 32'h0000_0000, 0, 2, 1, 32'h0000_0000, 0,   1, 0, 32'h0040_0293, 0, 32'h0000_020C, 5, 0);
    // three wait states: only the word present on the last wait edge is returned
    add(0, 1, NS, 32'h0000_0204, 0, 2, 1, 32'hDEAD_0001, 3,   0, 0, 32'h0040_0293, 0, 32'h0000_020C, 5, 0);
    add(0, 0, ID, 32'h0000_0000, 0, 2, 1, 32'hDEAD_0002, 0,   0, 0, 32'h0040_0293, 0, 32'h0000_020C, 5, 0);
    add(0, 0, ID, 32'h0000_0000, 0, 2, 1, 32'hDEAD_0003, 0,   0, 0, 32'h0040_0293, 0, 32'h0000_020C, 5, 0);
    add(0, 0, ID, 32'h0000_0000, 0, 2, 1, 32'h00A0_0313, 0,   1, 0, 32'h00A0_0313, 1, 32'h0000_0204, 6, 0);
    add(0, 0, ID, 32'h0000_0000, 0, 2, 1, 32'h0000_0000, 0,   1, 0, 32'h00A0_0313, 0, 32'h0000_0204, 6, 0);
    // wait_i=15 clamps to MAX_WAIT=4
    add(0, 1, NS, 32'h0000_0208, 0, 2, 1, 32'hDEAD_0004, 15,  0, 0, 32'h00A0_0313, 0, 32'h0000_0204, 6, 0);
    add(0, 0, ID, 32'h0000_0000, 0, 2, 1, 32'hDEAD_0005, 0,   0, 0, 32'h00A0_0313, 0, 32'h0000_0204, 6, 0);
    add(0, 0, ID, 32'h0000_0000, 0, 2, 1, 32'hDEAD_0006, 0,   0, 0, 32'h00A0_0313, 0, 32'h0000_0204, 6, 0);
    add(0, 0, ID, 32'h0000_0000, 0, 2, 1, 32'hDEAD_0007, 0,   0, 0, 32'h00A0_0313, 0, 32'h0000_0204, 6, 0);
    add(0, 0, ID, 32'h0000_0000, 0, 2, 1, 32'h00B0_0393, 0,   1, 0, 32'h00B0_0393, 1, 32'h0000_0208, 7, 0);
    // write is illegal (pipelined from DONE); master changes during ERR1 are ignored
    add(0, 1, NS, 32'h0000_0100, 1, 2, 1, 32'h1111_0000, 0,   0, 1, 32'h00B0_0393, 0, 32'h0000_0208, 7, 1);
    add(0, 1, NS, 32'h0000_0300, 0, 2, 1, 32'h1111_0001, 0,   1, 1, 32'h00B0_0393, 0, 32'h0000_0208, 7, 1);
    add(0, 1, NS, 32'h0000_0202, 0, 2, 1, 32'h1111_0002, 0,   0, 1, 32'h00B0_0393, 0, 32'h0000_0208, 7, 2);
    add(0, 0, ID, 32'h0000_0000, 0, 2, 1, 32'h0000_0000, 0,   1, 1, 32'h00B0_0393, 0, 32'h0000_0208, 7, 2);
    add(0, 1, NS, 32'h0001_0000, 0, 2, 1, 32'h1111_0003, 0,   0, 1, 32'h00B0_0393, 0, 32'h0000_0208, 7, 3);
    add(0, 0, ID, 32'h0000_0000, 0, 2, 1, 32'h0000_0000, 0,   1, 1, 32'h00B0_0393, 0, 32'h0000_0208, 7, 3);
    add(0, 1, NS, 32'h0000_0210, 0, 2, 1, 32'h00C0_0413, 0,   1, 0, 32'h00C0_0413, 1, 32'h0000_0210, 8, 3);
    add(0, 1, NS, 32'h0000_0000, 0, 3, 1, 32'h1111_0004, 0,   0, 1, 32'h00C0_0413, 0, 32'h0000_0210, 8, 4);
    add(0, 0, ID, 32'h0000_0000, 0, 2, 1, 32'h0000_0000, 0,   1, 1, 32'h00C0_0413, 0, 32'h0000_0210, 8, 4);
    // last legal word, then a legal odd byte fetch, then a misaligned half
    add(0, 1, NS, 32'h0000_FFFC, 0, 2, 1, 32'h00D0_0493, 0,   1, 0, 32'h00D0_0493, 1, 32'h0000_FFFC, 9, 4);
    add(0, 1, NS, 32'h0000_0003, 0, 0, 1, 32'h00E0_0513, 0,   1, 0, 32'h00E0_0513, 1, 32'h0000_0003, 10, 4);
    add(0, 1, NS, 32'h0000_0001, 0, 1, 1, 32'h1111_0005, 0,   0, 1, 32'h00E0_0513, 0, 32'h0000_0003, 10, 5);
    add(0, 0, ID, 32'h0000_0000, 0, 2, 1, 32'h0000_0000, 0,   1, 1, 32'h00E0_0513, 0, 32'h0000_0003, 10, 5);
    // BUSY, IDLE, deselected NONSEQ, and NONSEQ with HREADY low are all ignored
    add(0, 1, BZ, 32'h0000_0400, 0, 2, 1, 32'h1111_0006, 0,   1, 0, 32'h00E0_0513, 0, 32'h0000_0003, 10, 5);
    add(0, 1, ID, 32'h0000_0400, 0, 2, 1, 32'h1111_0007, 0,   1, 0, 32'h00E0_0513, 0, 32'h0000_0003, 10, 5);
    add(0, 0, NS, 32'h0000_0400, 0, 2, 1, 32'h1111_0008, 0,   1, 0, 32'h00E0_0513, 0, 32'h0000_0003, 10, 5);
    add(0, 1, NS, 32'h0000_0400, 0, 2, 0, 32'h1111_0009, 0,   1, 0, 32'h00E0_0513, 0, 32'h0000_0003, 10, 5);
    // reset while waiting with two wait states left
    add(0, 1, NS, 32'h0000_0220, 0, 2, 1, 32'h2222_0000, 3,   0, 0, 32'h00E0_0513, 0, 32'h0000_0003, 10, 5);
    add(0, 0, ID, 32'h0000_0000, 0, 2, 1, 32'h2222_0001, 0,   0, 0, 32'h00E0_0513, 0, 32'h0000_0003, 10, 5);
    add(1, 0, ID, 32'h0000_0000, 0, 2, 1, 32'h2222_0002, 0,   1, 0, 32'h0000_0013, 0, 32'h0000_0000, 0, 0);
    add(0, 0, ID, 32'h0000_0000, 0, 2, 1, 32'h2222_0003, 0,   1, 0, 32'h0000_0013, 0, 32'h0000_0000, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      HRESET = vq[i].rst;   HSEL  = vq[i].hsel;  HTRANS = vq[i].htrans;
      HADDR  = vq[i].haddr; HWRITE = vq[i].hwrite; HSIZE = vq[i].hsize;
      HREADY = vq[i].hready; insn_i = vq[i].insn; wait_i = vq[i].wt;
      @(posedge HCLK);
      #1;
      vectors_applied++;
      chk("HREADYOUT", i, 32'(HREADYOUT), 32'(vq[i].e_ro));
      chk("HRESP", i, 32'(HRESP), 32'(vq[i].e_resp));
      chk("HRDATA", i, HRDATA, vq[i].e_rdata);
      chk("fetch_valid_o", i, 32'(fetch_valid_o), 32'(vq[i].e_v));
      chk("fetch_addr_o", i, fetch_addr_o, vq[i].e_fa);
      chk("fetch_data_o", i, fetch_data_o, vq[i].e_rdata);
      chk("fetch_cnt_o", i, fetch_cnt_o, vq[i].e_fc);
      chk("err_cnt_o", i, 32'(err_cnt_o), 32'(vq[i].e_ec));
      $display("vec %0d: trans=%0d addr=%h -> ready=%0b resp=%0b rdata=%h valid=%0b fcnt=%0d ecnt=%0d",
               i, vq[i].htrans, vq[i].haddr, HREADYOUT, HRESP, HRDATA, fetch_valid_o,
               fetch_cnt_o, err_cnt_o);
    end

    // Two-wait fetch from a clean reset: count stall cycles until the completion pulse.
    drive_idle();
    HSEL = 1'b1; HTRANS = NS; HADDR = 32'h0000_0240; wait_i = 4'd2; insn_i = 32'h1111_1111;
    @(posedge HCLK);
    #1;
    drive_idle();
    insn_i = 32'h2222_2222;
    lows   = 0;
    cycles = 0;
    while (!fetch_valid_o && cycles < 20) begin
      if (!HREADYOUT) lows++;
      @(posedge HCLK);
      #1;
      cycles++;
    end
    vectors_applied++;
    if (!fetch_valid_o) begin
      miscompares++;
      $display("FAIL seq wait2 timeout: no fetch_valid_o within %0d cycles", cycles);
    end
    chk("seq wait2 stall cycles", vq.size(), 32'(lows), 32'd2);
    chk("seq wait2 HRDATA", vq.size(), HRDATA, 32'h2222_2222);
    chk("seq wait2 fetch_addr_o", vq.size(), fetch_addr_o, 32'h0000_0240);
    chk("seq wait2 fetch_cnt_o", vq.size(), fetch_cnt_o, 32'd1);
    $display("seq wait2: stalls=%0d rdata=%h addr=%h fcnt=%0d", lows, HRDATA, fetch_addr_o, fetch_cnt_o);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
